// File: rtl/hyper_tf_splitter.sv
// HyperBus transfer splitter.
// Takes one linear transfer request (byte address plus length in 16-bit words)
// and emits it as a series of sub-transfers, each with a pre-built 48-bit
// command-address word. Every sub-transfer is at most cfg_burst_max_i words
// long, where 0 means unlimited. The word address wraps inside the window
// selected by cfg_addr_msb_i.
//
// Handshake (both ports): a beat transfers on a rising clk edge where
// valid & ready are both 1. A source holds valid and its payload stable
// until that edge. in_ready_o may depend on out_ready_i in the same cycle,
// so a new request can be taken on the same edge as the final sub-transfer.
module hyper_tf_splitter #(
    parameter int AddrWidth        = 32,
    parameter int BurstWidth       = 15,
    parameter int NumPhys          = 1,
    parameter int MaxBurstCfgWidth = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [MaxBurstCfgWidth-1:0] cfg_burst_max_i,
    input  logic [4:0]                  cfg_addr_msb_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic                        in_write_i,
    input  logic                        in_space_i,
    input  logic                        in_btype_i,
    input  logic [AddrWidth-1:0]        in_addr_i,
    input  logic [BurstWidth-1:0]       in_burst_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [47:0]                 out_ca_o,
    output logic [BurstWidth-1:0]       out_burst_o,
    output logic                        out_first_o,
    output logic                        out_last_o,
    output logic                        err_o,
    output logic                        dbg_split_o
);

    // One 16-bit word per PHY per byte pair, so two PHYs shift by one more bit.
    localparam int Shift = (NumPhys == 2) ? 2 : 1;
    // Common width used to compare a remaining length against the cfg maximum.
    localparam int CmpWidth = (BurstWidth > MaxBurstCfgWidth) ? BurstWidth : MaxBurstCfgWidth;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    state_e                      state_q, state_d;
    logic [31:0]                 waddr_q, waddr_d;
    logic [31:0]                 mask_q, mask_d;
    logic [BurstWidth-1:0]       rem_q, rem_d;
    logic [MaxBurstCfgWidth-1:0] max_q, max_d;
    logic                        write_q, write_d;
    logic                        space_q, space_d;
    logic                        btype_q, btype_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_first_q, out_first_d;
    logic                        out_last_q, out_last_d;
    logic [BurstWidth-1:0]       out_burst_q, out_burst_d;
    logic [47:0]                 out_ca_q, out_ca_d;
    logic                        err_q, err_d;

    logic                        in_ready;
    logic                        accept;
    logic                        out_hs;
    logic [31:0]                 addr_word;
    logic [31:0]                 new_mask;
    logic [31:0]                 new_waddr;
    logic [BurstWidth-1:0]       new_sub;
    logic [BurstWidth-1:0]       next_rem;
    logic [31:0]                 next_waddr;
    logic [BurstWidth-1:0]       next_sub;

    // Length of the next sub-transfer: the whole remainder when the maximum is
    // 0 or not smaller than it, otherwise the maximum.
    function automatic logic [BurstWidth-1:0] sub_len(
        input logic [BurstWidth-1:0]       rem,
        input logic [MaxBurstCfgWidth-1:0] mx
    );
        logic [CmpWidth-1:0] rem_ext;
        logic [CmpWidth-1:0] mx_ext;
        rem_ext = CmpWidth'(rem);
        mx_ext  = CmpWidth'(mx);
        if (mx == '0 || rem_ext <= mx_ext) begin
            sub_len = rem;
        end else begin
            sub_len = BurstWidth'(mx_ext);
        end
    endfunction

    // Command-address word: R/W#, address space, burst type, upper word
    // address, reserved zeros, lower word address.
    function automatic logic [47:0] make_ca(
        input logic        wr,
        input logic        sp,
        input logic        bt,
        input logic [31:0] wa
    );
        make_ca = {~wr, sp, bt, wa[31:3], 13'b0, wa[2:0]};
    endfunction

    assign addr_word = 32'(in_addr_i >> Shift);

    // Request acceptance and per-sub-transfer address/length arithmetic.
    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        mask_d      = mask_q;
        rem_d       = rem_q;
        max_d       = max_q;
        write_d     = write_q;
        space_d     = space_q;
        btype_d     = btype_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        out_burst_d = out_burst_q;
        out_ca_d    = out_ca_q;
        err_d       = 1'b0;

        // Idle always takes a request; Split only on the edge the last
        // sub-transfer leaves, so the next request follows without a gap.
        if (state_q == IDLE) begin
            in_ready = 1'b1;
        end else begin
            in_ready = out_valid_q & out_ready_i & out_last_q;
        end
        accept = in_valid_i & in_ready;
        out_hs = out_valid_q & out_ready_i;

        // Values for a freshly accepted request, using cfg as seen right now.
        new_mask  = 32'hFFFF_FFFF >> (5'd31 - cfg_addr_msb_i);
        new_waddr = addr_word & new_mask;
        new_sub   = sub_len(in_burst_i, cfg_burst_max_i);

        // Values for the following sub-transfer of the current request,
        // using cfg latched at accept.
        next_rem   = rem_q - out_burst_q;
        next_waddr = (waddr_q + 32'(out_burst_q)) & mask_q;
        next_sub   = sub_len(next_rem, max_q);

        if (state_q == SPLIT && out_hs) begin
            if (!out_last_q) begin
                rem_d       = next_rem;
                waddr_d     = next_waddr;
                out_burst_d = next_sub;
                out_last_d  = (next_rem <= next_sub);
                out_first_d = 1'b0;
                out_ca_d    = make_ca(write_q, space_q, btype_q, next_waddr);
            end else begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        end

        if (accept) begin
            if (in_burst_i == '0) begin
                // Zero-length request: swallow it and flag it for one cycle.
                err_d       = 1'b1;
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end else begin
                state_d     = SPLIT;
                mask_d      = new_mask;
                waddr_d     = new_waddr;
                rem_d       = in_burst_i;
                max_d       = cfg_burst_max_i;
                write_d     = in_write_i;
                space_d     = in_space_i;
                btype_d     = in_btype_i;
                out_valid_d = 1'b1;
                out_first_d = 1'b1;
                out_burst_d = new_sub;
                out_last_d  = (in_burst_i <= new_sub);
                out_ca_d    = make_ca(in_write_i, in_space_i, in_btype_i, new_waddr);
            end
        end
    end

    // State and output registers; reset drops any split in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            mask_q      <= '0;
            rem_q       <= '0;
            max_q       <= '0;
            write_q     <= 1'b0;
            space_q     <= 1'b0;
            btype_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_burst_q <= '0;
            out_ca_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            mask_q      <= mask_d;
            rem_q       <= rem_d;
            max_q       <= max_d;
            write_q     <= write_d;
            space_q     <= space_d;
            btype_q     <= btype_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_burst_q <= out_burst_d;
            out_ca_q    <= out_ca_d;
            err_q       <= err_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;
    assign out_first_o = out_first_q;
    assign out_last_o  = out_last_q;
    assign out_burst_o = out_burst_q;
    assign out_ca_o    = out_ca_q;
    assign err_o       = err_q;
    assign dbg_split_o = (state_q == SPLIT);

endmodule

// File: tb/tb_hyper_tf_splitter.sv
// Directed bench for hyper_tf_splitter: one instance with one PHY and one
// with two PHYs. Both instances share the same stimulus.
module tb_hyper_tf_splitter;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] cfg_burst_max = '0;
    logic [4:0]  cfg_addr_msb = 5'd31;
    logic        in_valid = 1'b0;
    logic        in_write = 1'b0;
    logic        in_space = 1'b0;
    logic        in_btype = 1'b0;
    logic [31:0] in_addr = '0;
    logic [14:0] in_burst = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_first, out_last, err, dbg_split;
    logic [47:0] out_ca;
    logic [14:0] out_burst;
    logic        in_ready2, out_valid2, out_first2, out_last2, err2, dbg_split2;
    logic [47:0] out_ca2;
    logic [14:0] out_burst2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hyper_tf_splitter #(.NumPhys(1)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cfg_burst_max_i(cfg_burst_max), .cfg_addr_msb_i(cfg_addr_msb),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_write_i(in_write), .in_space_i(in_space), .in_btype_i(in_btype),
        .in_addr_i(in_addr), .in_burst_i(in_burst),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_ca_o(out_ca), .out_burst_o(out_burst),
        .out_first_o(out_first), .out_last_o(out_last),
        .err_o(err), .dbg_split_o(dbg_split)
    );

    hyper_tf_splitter #(.NumPhys(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_ni),
        .cfg_burst_max_i(cfg_burst_max), .cfg_addr_msb_i(cfg_addr_msb),
        .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .in_write_i(in_write), .in_space_i(in_space), .in_btype_i(in_btype),
        .in_addr_i(in_addr), .in_burst_i(in_burst),
        .out_valid_o(out_valid2), .out_ready_i(out_ready),
        .out_ca_o(out_ca2), .out_burst_o(out_burst2),
        .out_first_o(out_first2), .out_last_o(out_last2),
        .err_o(err2), .dbg_split_o(dbg_split2)
    );

    // Expected command-address word built from the field layout.
    function automatic logic [47:0] exp_ca(input logic wr, input logic sp,
                                           input logic bt, input logic [31:0] wa);
        exp_ca = {~wr, sp, bt, wa[31:3], 13'b0, wa[2:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sub(input string tag, input logic [14:0] b, input logic [31:0] wa,
                           input logic wr, input logic f, input logic l);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
        chk({tag, "_burst"}, 64'(out_burst), 64'(b));
        chk({tag, "_ca"}, 64'(out_ca), 64'(exp_ca(wr, 1'b0, 1'b1, wa)));
        chk({tag, "_first"}, 64'(out_first), 64'(f));
        chk({tag, "_last"}, 64'(out_last), 64'(l));
    endtask

    task automatic send(input logic wr, input logic [31:0] a, input logic [14:0] b);
        in_valid = 1'b1;
        in_write = wr;
        in_btype = 1'b1;
        in_addr  = a;
        in_burst = b;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_ca", 64'(out_ca), 64'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        chk("rst_ready", 64'(in_ready), 64'(1'b1));
        chk("rst_err", 64'(err), 64'(1'b0));
        chk("rst_burst", 64'(out_burst), 64'(0));
        chk("rst_fl", 64'({out_first, out_last}), 64'(0));
        chk("rst_idle", 64'(dbg_split), 64'(1'b0));

        // Read 0x1000, burst 40, max 16 -> 16/16/8 at 0x800/0x810/0x820
        cfg_burst_max = 16'd16;
        send(1'b0, 32'h1000, 15'd40);
        tick();
        in_valid = 1'b0;
        chk_sub("r40_s1", 15'd16, 32'h800, 1'b0, 1'b1, 1'b0);
        tick();
        chk_sub("r40_s2", 15'd16, 32'h810, 1'b0, 1'b0, 1'b0);
        tick();
        chk_sub("r40_s3", 15'd8, 32'h820, 1'b0, 1'b0, 1'b1);
        tick();
        chk("r40_done", 64'(out_valid), 64'(1'b0));
        chk("r40_idle", 64'(dbg_split), 64'(1'b0));

        // Write, burst 5, unlimited -> single sub
        cfg_burst_max = 16'd0;
        send(1'b1, 32'h40, 15'd5);
        tick();
        in_valid = 1'b0;
        chk_sub("w5", 15'd5, 32'h20, 1'b1, 1'b1, 1'b1);
        chk("w5_ca47", 64'(out_ca[47]), 64'(1'b0));
        tick();
        chk("w5_done", 64'(out_valid), 64'(1'b0));

        // Two PHYs, 0xFFC, msb 9, burst 8, max 4 -> 0x3FF then wrap to 0x003
        cfg_burst_max = 16'd4;
        cfg_addr_msb = 5'd9;
        send(1'b0, 32'hFFC, 15'd8);
        tick();
        in_valid = 1'b0;
        chk("wrap_s1_ca", 64'(out_ca2), 64'(exp_ca(1'b0, 1'b0, 1'b1, 32'h3FF)));
        chk("wrap_s1_b", 64'({out_burst2, out_first2, out_last2}), 64'({15'd4, 1'b1, 1'b0}));
        tick();
        chk("wrap_s2_ca", 64'(out_ca2), 64'(exp_ca(1'b0, 1'b0, 1'b1, 32'h003)));
        chk("wrap_s2_b", 64'({out_burst2, out_first2, out_last2}), 64'({15'd4, 1'b0, 1'b1}));
        chk("wrap_p1_ca", 64'(out_ca), 64'(exp_ca(1'b0, 1'b0, 1'b1, 32'h002)));
        tick();
        chk("wrap_done", 64'(out_valid2), 64'(1'b0));

        // Back-pressure on the second sub; cfg changes mid-split are ignored
        cfg_burst_max = 16'd16;
        cfg_addr_msb = 5'd31;
        send(1'b0, 32'h0, 15'd48);
        tick();
        in_valid = 1'b0;
        cfg_burst_max = 16'd2;
        cfg_addr_msb = 5'd3;
        chk_sub("bp_s1", 15'd16, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        out_ready = 1'b0;
        chk_sub("bp_s2", 15'd16, 32'h10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_sub("bp_hold", 15'd16, 32'h10, 1'b0, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        chk_sub("bp_s3", 15'd16, 32'h20, 1'b0, 1'b0, 1'b1);
        tick();
        chk("bp_done", 64'(out_valid), 64'(1'b0));

        // Same-cycle accept on the last handshake
        cfg_burst_max = 16'd16;
        cfg_addr_msb = 5'd31;
        send(1'b0, 32'h200, 15'd20);
        tick();
        in_valid = 1'b0;
        chk_sub("b2b_s1", 15'd16, 32'h100, 1'b0, 1'b1, 1'b0);
        #1;
        chk("b2b_ready_lo", 64'(in_ready), 64'(1'b0));
        tick();
        chk_sub("b2b_s2", 15'd4, 32'h110, 1'b0, 1'b0, 1'b1);
        send(1'b1, 32'h400, 15'd3);
        #1;
        chk("b2b_ready_hi", 64'(in_ready), 64'(1'b1));
        tick();
        in_valid = 1'b0;
        chk_sub("b2b_new", 15'd3, 32'h200, 1'b1, 1'b1, 1'b1);
        tick();
        chk("b2b_done", 64'(out_valid), 64'(1'b0));

        // Zero-length request: one-cycle err, no output
        send(1'b0, 32'h80, 15'd0);
        #1;
        chk("z_ready", 64'(in_ready), 64'(1'b1));
        tick();
        in_valid = 1'b0;
        chk("z_err1", 64'(err), 64'(1'b1));
        chk("z_valid1", 64'(out_valid), 64'(1'b0));
        tick();
        chk("z_err2", 64'(err), 64'(1'b0));
        chk("z_valid2", 64'(out_valid), 64'(1'b0));

        // Asynchronous reset in the middle of a split
        send(1'b0, 32'h1000, 15'd40);
        tick();
        in_valid = 1'b0;
        chk("mr_valid_pre", 64'(out_valid), 64'(1'b1));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mr_valid", 64'(out_valid), 64'(1'b0));
        chk("mr_idle", 64'(dbg_split), 64'(1'b0));
        chk("mr_ca", 64'(out_ca), 64'(0));
        chk("mr_fl", 64'({out_first, out_last, err}), 64'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        chk("mr_after_valid", 64'(out_valid), 64'(1'b0));
        chk("mr_after_ready", 64'(in_ready), 64'(1'b1));
        tick();
        chk("mr_after_valid2", 64'(out_valid), 64'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
